// File: rtl/shift_pipe_ctrl.sv
// Two-stage shift pipeline: stage 1 registers the request, stage 2 registers the
// shifted result and flags. Full valid/ready backpressure, at most two in flight.
module shift_pipe_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         sat,
    output logic         zero,
    output logic [7:0]   count
);
    localparam int LOGN = $clog2(N);

    typedef enum logic [1:0] {OP_SLL = 2'd0, OP_SRL = 2'd1, OP_SRA = 2'd2, OP_ROR = 2'd3} op_e;

    logic         s1_valid, s2_valid, s2_free;
    op_e          s1_op;
    logic [N-1:0] s1_a, s1_b;

    assign s2_free   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_free;
    assign out_valid = s2_valid;

    logic [LOGN-1:0] amt;
    logic            big;
    logic [N-1:0]    a_rev, sll_rev, sll_y, srl_y, sra_y, ror_y;

    assign amt = s1_b[LOGN-1:0];
    assign big = |s1_b[N-1:LOGN];

    // Left shift reuses the right-shift network on the bit-reversed operand.
    for (genvar i = 0; i < N; i++) begin : g_rev
        assign a_rev[i] = s1_a[N-1-i];
        assign sll_y[i] = sll_rev[N-1-i];
    end

    shr_net #(.N(N), .LOGN(LOGN)) u_sll (.a(a_rev), .sh(amt), .rot(1'b0), .fill(1'b0), .y(sll_rev));
    shr_net #(.N(N), .LOGN(LOGN)) u_srl (.a(s1_a),  .sh(amt), .rot(1'b0), .fill(1'b0), .y(srl_y));
    shr_net #(.N(N), .LOGN(LOGN)) u_ror (.a(s1_a),  .sh(amt), .rot(1'b1), .fill(1'b0), .y(ror_y));
    sran    #(.N(N))              u_sra (.a(s1_a),  .b(s1_b), .y(sra_y));

    logic [N-1:0] c_res;
    logic         c_sat;

    always_comb begin
        c_res = '0;
        c_sat = big;
        case (s1_op)
            OP_SLL: c_res = big ? '0 : sll_y;
            OP_SRL: c_res = big ? '0 : srl_y;
            OP_SRA: c_res = sra_y;
            OP_ROR: begin
                c_res = ror_y;
                c_sat = 1'b0;
            end
            default: c_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_SLL;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            result   <= '0;
            sat      <= 1'b0;
            zero     <= 1'b0;
            count    <= '0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid <= 1'b1;
                s1_op    <= op_e'(op);
                s1_a     <= a;
                s1_b     <= b;
            end else if (s2_free) begin
                s1_valid <= 1'b0;
            end
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    result <= c_res;
                    sat    <= c_sat;
                    zero   <= (c_res == '0);
                end
            end
            if (s2_valid && out_ready)
                count <= count + 8'd1;
        end
    end
endmodule

// Arithmetic right shift with sign fill once the full-width amount reaches N.
module sran #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);
    localparam int LOGN = $clog2(N);
    logic [N-1:0] net_y;

    shr_net #(.N(N), .LOGN(LOGN)) u_net (.a(a), .sh(b[LOGN-1:0]), .rot(1'b0), .fill(a[N-1]), .y(net_y));
    assign y = (|b[N-1:LOGN]) ? {N{a[N-1]}} : net_y;
endmodule

// Log-depth right shifter of mux2x1 cells; bits shifted in come from the
// wrapped operand (rotate) or from the fill bit.
module shr_net #(
    parameter int N    = 8,
    parameter int LOGN = 3
) (
    input  logic [N-1:0]    a,
    input  logic [LOGN-1:0] sh,
    input  logic            rot,
    input  logic            fill,
    output logic [N-1:0]    y
);
    for (genvar k = 0; k < LOGN; k++) begin : g_stg
        logic [N-1:0] src, dst;
        if (k == 0) begin : g_first
            assign src = a;
        end else begin : g_next
            assign src = g_stg[k-1].dst;
        end
        for (genvar i = 0; i < N; i++) begin : g_bit
            logic hi;
            if (i + (1 << k) < N) begin : g_in
                assign hi = src[i + (1 << k)];
            end else begin : g_wrap
                assign hi = rot ? src[i + (1 << k) - N] : fill;
            end
            mux2x1 u_mux (.d0(src[i]), .d1(hi), .s(sh[k]), .y(dst[i]));
        end
    end
    assign y = g_stg[LOGN-1].dst;
endmodule

module mux2x1 (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);
    assign y = s ? d1 : d0;
endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// Bench for shift_pipe_ctrl: directed latency/saturation/backpressure/reset cases
// plus a random stream scored against an arithmetic reference model.
module tb_shift_pipe_ctrl;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [1:0]   op = '0;
    logic [N-1:0] a = '0, b = '0;
    logic         out_valid, out_ready = 1'b0;
    logic [N-1:0] result;
    logic         sat, zero;
    logic [7:0]   count;

    shift_pipe_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sat(sat), .zero(zero), .count(count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int ndone = 0;
    int npop  = 0;
    logic [7:0] mcount = '0;
    logic [N+1:0] q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: {result, sat, zero} from the shift rules in plain arithmetic.
    function automatic logic [N+1:0] model(input logic [1:0] mop, input logic [N-1:0] ma,
                                           input logic [N-1:0] mb);
        logic [N-1:0]   r;
        logic           s;
        logic [2*N-1:0] w;
        s = (mop != 2'd3) && (int'(mb) >= N);
        case (mop)
            2'd0: r = s ? '0 : N'(ma << mb);
            2'd1: r = s ? '0 : N'(ma >> mb);
            2'd2: r = s ? {N{ma[N-1]}} : N'($signed(ma) >>> mb);
            default: begin
                w = {ma, ma} >> (int'(mb) % N);
                r = w[N-1:0];
            end
        endcase
        return {r, s, r == '0};
    endfunction

    // Scoreboard: sampled mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mcount = '0;
        end else begin
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
            chk("m_count", {24'd0, count}, {24'd0, mcount});
            if (out_valid) begin
                chk("m_q_nonempty", {31'd0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    chk("m_out", {22'd0, result, sat, zero}, {22'd0, q[0]});
                    if (out_ready) begin
                        void'(q.pop_front());
                        mcount = mcount + 8'd1;
                        npop++;
                    end
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(op, a, b));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        ndone = 0;
    endtask

    // Single request with out_ready high: check latency 2, the result and count.
    task automatic issue_chk(input logic [1:0] iop, input logic [N-1:0] ia, input logic [N-1:0] ib,
                             input logic [N-1:0] er, input logic es, input logic ez);
        op = iop; a = ia; b = ib; in_valid = 1'b1;
        #1;
        chk("req_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("lat_t1_out_valid", {31'd0, out_valid}, 32'd0);
        cyc();
        chk("lat_t2_out_valid", {31'd0, out_valid}, 32'd1);
        chk("result", {24'd0, result}, {24'd0, er});
        chk("sat", {31'd0, sat}, {31'd0, es});
        chk("zero", {31'd0, zero}, {31'd0, ez});
        cyc();
        ndone++;
        chk("count", {24'd0, count}, 32'(ndone & 8'hFF));
    endtask

    logic [1:0]   bp_op [4];
    logic [N-1:0] bp_a [4], bp_b [4];
    logic [N+1:0] bp_exp;

    initial begin
        int nxt, sent, cyc_cnt;
        logic acc;

        cyc();
        cyc();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {24'd0, count}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;

        issue_chk(2'd2, 8'hB4, 8'd2,  8'hED, 1'b0, 1'b0);
        issue_chk(2'd2, 8'h80, 8'h09, 8'hFF, 1'b1, 1'b0);
        issue_chk(2'd0, 8'hFF, 8'h40, 8'h00, 1'b1, 1'b1);
        issue_chk(2'd1, 8'h81, 8'd7,  8'h01, 1'b0, 1'b0);
        issue_chk(2'd3, 8'h01, 8'h09, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            issue_chk(2'(i), 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0);

        // Backpressure: two accepts then stall, then drain four in order.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bp_op[i] = 2'($urandom_range(0, 3));
            bp_a[i]  = 8'($urandom);
            bp_b[i]  = 8'($urandom_range(1, 7));
        end
        for (int i = 0; i < 2; i++) begin
            op = bp_op[i]; a = bp_a[i]; b = bp_b[i]; in_valid = 1'b1;
            #1;
            chk("bp_accept_ready", {31'd0, in_ready}, 32'd1);
            cyc();
        end
        op = bp_op[2]; a = bp_a[2]; b = bp_b[2];
        #1;
        chk("bp_in_ready_drop", {31'd0, in_ready}, 32'd0);
        bp_exp = model(bp_op[0], bp_a[0], bp_b[0]);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_stall_result", {24'd0, result}, {24'd0, bp_exp[N+1:2]});
        end
        out_ready = 1'b1;
        nxt = 2;
        for (int c = 0; c < 4; c++) begin
            #1;
            bp_exp = model(bp_op[c], bp_a[c], bp_b[c]);
            chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_drain_result", {24'd0, result}, {24'd0, bp_exp[N+1:2]});
            acc = in_valid && in_ready;
            cyc();
            if (acc) nxt++;
            in_valid = (nxt < 4);
            if (nxt < 4) begin
                op = bp_op[nxt]; a = bp_a[nxt]; b = bp_b[nxt];
            end
        end
        #1;
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        chk("bp_count", {24'd0, count}, 32'd4);

        // Random stream of 300 with random backpressure.
        do_reset();
        npop = 0;
        sent = 0;
        cyc_cnt = 0;
        op = 2'($urandom_range(0, 3));
        a  = 8'($urandom);
        b  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
        while (sent < 300 && cyc_cnt < 5000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            #1;
            acc = in_valid && in_ready;
            cyc();
            cyc_cnt++;
            if (acc) begin
                sent++;
                op = 2'($urandom_range(0, 3));
                a  = 8'($urandom);
                b  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            end
        end
        chk("stream_sent_in_budget", sent, 300);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc_cnt = 0;
        while ((out_valid || q.size() != 0) && cyc_cnt < 20) begin
            cyc();
            cyc_cnt++;
        end
        chk("stream_drained", {31'd0, out_valid || q.size() != 0}, 32'd0);
        chk("stream_popped", npop, 300);
        chk("stream_count_wrap", {24'd0, count}, 32'd44);

        // Reset with both stages full and a request pending.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op = 2'd1; a = 8'($urandom); b = 8'd1; in_valid = 1'b1;
            cyc();
        end
        #1;
        chk("full_before_rst", {31'd0, out_valid && !in_ready}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
        ndone = 0;
        #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_count", {24'd0, count}, 32'd0);
        out_ready = 1'b1;
        issue_chk(2'd0, 8'h03, 8'd2, 8'h0C, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
